// File: rtl/bsg_clk_gen_pearl_tag_tx.sv
// bsg_tag serial transmitter: parallel packet in, START/LEN/DNR/ID/PAYLOAD bits out one per cycle, LSB first.
// Optional inter-packet GAP state enabled by defining BSG_CLK_GEN_PEARL_TAG_TX_GAP_EN.
module bsg_clk_gen_pearl_tag_tx #(
  parameter int els_p               = 16,
  parameter int lg_width_p          = 4,
  parameter int max_payload_width_p = 10,
  parameter int gap_p               = 4,
  localparam int id_w = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           v_i,
  output logic                           ready_o,
  input  logic [id_w-1:0]                node_id_i,
  input  logic                           data_not_reset_i,
  input  logic [lg_width_p-1:0]          len_i,
  input  logic [max_payload_width_p-1:0] payload_i,
  output logic                           tag_data_o,
  output logic                           tag_en_o
);

  localparam int field_max_a = (lg_width_p > id_w) ? lg_width_p : id_w;
  localparam int field_max   = (field_max_a > max_payload_width_p) ? field_max_a : max_payload_width_p;
`ifdef BSG_CLK_GEN_PEARL_TAG_TX_GAP_EN
  localparam int cnt_max = (field_max > gap_p) ? field_max : gap_p;
`else
  localparam int cnt_max = field_max;
`endif
  localparam int cnt_w = $clog2(cnt_max + 1);
  localparam int pkt_w = 2 + lg_width_p + id_w + max_payload_width_p;
  localparam logic [lg_width_p-1:0] max_len = lg_width_p'(max_payload_width_p);

`ifdef BSG_CLK_GEN_PEARL_TAG_TX_GAP_EN
  typedef enum logic [2:0] {IDLE, START, LEN, DNR, ID, PAYLOAD, GAP} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, LEN, DNR, ID, PAYLOAD} state_e;
  logic unused_gap;
  assign unused_gap = (gap_p != 0);
`endif

  state_e                  state_r, state_n, done_state;
  logic [cnt_w-1:0]        cnt_r, cnt_n, done_cnt;
  logic [pkt_w-1:0]        sr_r, sr_n;
  logic [lg_width_p-1:0]   len_r, len_n, len_c;
  logic                    last, active;

  assign ready_o = (state_r == IDLE) & ~reset_i;
  assign len_c   = (len_i > max_len) ? max_len : len_i;
  assign last    = (cnt_r == cnt_w'(1));

  always_comb begin
    active = (state_r != IDLE);
`ifdef BSG_CLK_GEN_PEARL_TAG_TX_GAP_EN
    if (state_r == GAP) active = 1'b0;
`endif
  end

  // Where the FSM goes once the final bit of a packet has been driven.
  always_comb begin
    done_state = IDLE;
    done_cnt   = '0;
`ifdef BSG_CLK_GEN_PEARL_TAG_TX_GAP_EN
    if (gap_p > 0) begin
      done_state = GAP;
      done_cnt   = cnt_w'(gap_p);
    end
`endif
  end

  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    sr_n    = active ? (sr_r >> 1) : sr_r;
    len_n   = len_r;
    case (state_r)
      IDLE: begin
        if (v_i & ready_o) begin
          sr_n    = {payload_i, node_id_i, data_not_reset_i, len_c, 1'b1};
          len_n   = len_c;
          state_n = START;
        end
      end
      START: begin
        cnt_n   = cnt_w'(lg_width_p);
        state_n = LEN;
      end
      LEN: begin
        cnt_n = cnt_r - 1'b1;
        if (last) state_n = DNR;
      end
      DNR: begin
        cnt_n   = cnt_w'(id_w);
        state_n = ID;
      end
      ID: begin
        cnt_n = cnt_r - 1'b1;
        if (last) begin
          if (len_r == '0) begin
            state_n = done_state;
            cnt_n   = done_cnt;
          end else begin
            state_n = PAYLOAD;
            cnt_n   = cnt_w'(len_r);
          end
        end
      end
      PAYLOAD: begin
        cnt_n = cnt_r - 1'b1;
        if (last) begin
          state_n = done_state;
          cnt_n   = done_cnt;
        end
      end
`ifdef BSG_CLK_GEN_PEARL_TAG_TX_GAP_EN
      GAP: begin
        cnt_n = cnt_r - 1'b1;
        if (last) state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the current state, so they trail the FSM by one cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      sr_r       <= '0;
      len_r      <= '0;
      tag_data_o <= 1'b0;
      tag_en_o   <= 1'b0;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      sr_r       <= sr_n;
      len_r      <= len_n;
      tag_data_o <= active & sr_r[0];
      tag_en_o   <= active;
    end
  end

endmodule

// File: tb/tb_bsg_clk_gen_pearl_tag_tx.sv
// Directed and randomized bench for bsg_clk_gen_pearl_tag_tx (els_p=16, lg_width_p=4, max_payload_width_p=10).
module tb_bsg_clk_gen_pearl_tag_tx;
  logic       clk = 1'b0;
  logic       reset_i, v_i, data_not_reset_i;
  logic [3:0] node_id_i, len_i;
  logic [9:0] payload_i;
  logic       ready_o, tag_data_o, tag_en_o;

  int total = 0;
  int bad   = 0;

  typedef struct {int id; int dnr; int len; int pay;} pkt_t;
  pkt_t       pq[$];
  logic [1:0] exp_q[$];

`ifdef BSG_CLK_GEN_PEARL_TAG_TX_GAP_EN
  localparam int sep = 5;
`else
  localparam int sep = 1;
`endif

  bsg_clk_gen_pearl_tag_tx #(
    .els_p(16), .lg_width_p(4), .max_payload_width_p(10), .gap_p(4)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
    .node_id_i(node_id_i), .data_not_reset_i(data_not_reset_i),
    .len_i(len_i), .payload_i(payload_i),
    .tag_data_o(tag_data_o), .tag_en_o(tag_en_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: expected {tag_en, tag_data} stream for one packet, straight from the field layout.
  function automatic void push_pkt(input pkt_t p);
    int cl;
    cl = (p.len > 10) ? 10 : p.len;
    exp_q.push_back(2'b11);
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 1'((cl >> i) & 1)});
    exp_q.push_back({1'b1, 1'(p.dnr & 1)});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 1'((p.id >> i) & 1)});
    for (int i = 0; i < cl; i++) exp_q.push_back({1'b1, 1'((p.pay >> i) & 1)});
  endfunction

  task automatic drive(input pkt_t p);
    node_id_i        = p.id[3:0];
    data_not_reset_i = p.dnr[0];
    len_i            = p.len[3:0];
    payload_i        = p.pay[9:0];
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'b0, ready_o}, 32'd1);
  endtask

  // Sends every packet in pq with v_i held high and compares each cycle with the model stream.
  task automatic run(input string tag);
    int idx;
    bit pend;
    exp_q.delete();
    exp_q.push_back(2'b00);
    for (int k = 0; k < pq.size(); k++) begin
      push_pkt(pq[k]);
      if (k < pq.size() - 1) for (int j = 0; j < sep; j++) exp_q.push_back(2'b00);
    end
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    @(negedge clk);
    wait_ready();
    v_i = 1'b1;
    drive(pq[0]);
    idx  = 0;
    pend = 1'b1;
    for (int s = 0; s < exp_q.size(); s++) begin
      @(negedge clk);
      if (pend) begin
        idx++;
        if (idx < pq.size()) drive(pq[idx]);
        else v_i = 1'b0;
      end
      pend = v_i && ready_o;
      chk($sformatf("%s[%0d]", tag, s), {30'b0, tag_en_o, tag_data_o}, {30'b0, exp_q[s]});
    end
    v_i = 1'b0;
    pq.delete();
  endtask

  initial begin
    pkt_t p;
    reset_i = 1'b1;
    v_i = 1'b0;
    node_id_i = '0;
    data_not_reset_i = 1'b0;
    len_i = '0;
    payload_i = '0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_out", {30'b0, tag_en_o, tag_data_o}, 32'd0);
      chk("rst_ready", {31'b0, ready_o}, 32'd0);
    end
    reset_i = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, ready_o}, 32'd1);

    pq.push_back('{5, 1, 3, 5});
    run("data_pkt");

    pq.push_back('{2, 0, 0, int'($urandom_range(0, 1023))});
    run("zero_len");

    pq.push_back('{int'($urandom_range(0, 15)), 1, 3, int'($urandom_range(0, 7))});
    pq.push_back('{int'($urandom_range(0, 15)), 0, 3, int'($urandom_range(0, 7))});
    run("b2b");

    pq.push_back('{int'($urandom_range(0, 15)), 1, 15, 10'h3FF});
    run("clamp");

    p = '{9, 1, 10, int'($urandom_range(0, 1023))};
    @(negedge clk);
    wait_ready();
    v_i = 1'b1;
    drive(p);
    @(negedge clk);
    v_i = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_bit6_en", {31'b0, tag_en_o}, 32'd1);
    reset_i = 1'b1;
    @(negedge clk);
    chk("mid_rst_out", {30'b0, tag_en_o, tag_data_o}, 32'd0);
    chk("mid_rst_ready", {31'b0, ready_o}, 32'd0);
    reset_i = 1'b0;
    @(negedge clk);
    chk("mid_ready", {31'b0, ready_o}, 32'd1);
    pq.push_back('{6, 1, 7, int'($urandom_range(0, 1023))});
    run("after_rst");

    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++)
        pq.push_back('{int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                       int'($urandom_range(0, 15)), int'($urandom_range(0, 1023))});
      run($sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
